// File: rtl/sigma_wait_memory.sv
// Word-addressed bench memory for the Sigma CPU with a req/ready handshake,
// programmable wait states, byte-lane writes and alias/fault out-of-range handling.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on accept
// BUSY  | counting down wait states; access performed when the count is zero
// DONE  | one-cycle ready/fault pulse, then back to IDLE (req ignored)
module sigma_wait_memory #(
    parameter int    ADDR_BITS   = 17,
    parameter int    DEPTH       = 128,
    parameter int    WAIT_STATES = 1,
    parameter bit    ALIAS       = 1'b0,
    parameter string INIT_FILE   = ""
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   write_en,
    input  logic [32-ADDR_BITS:31] address,
    input  logic [0:3]             byte_en,
    input  logic [0:31]            data_in,
    output logic                   ready,
    output logic [0:31]            data_out,
    output logic                   fault
);
    localparam int                   IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS-1:0] DEPTH_A   = ADDR_BITS'(DEPTH);
    localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [3:0]             wcount;
    logic                   lat_write;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [0:3]             lat_be;
    logic [0:31]            lat_data;

    logic [0:31]            mem [DEPTH];

    logic [ADDR_BITS-1:0]   addr_mod;
    logic [IDX_BITS-1:0]    idx;
    logic                   in_range;
    logic                   access_ok;
    logic                   do_access;
    logic [0:31]            cur_word;
    logic [0:31]            merged;

    // Power-up image; reset never touches the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_comb begin
        addr_mod  = lat_addr % DEPTH_A;
        idx       = addr_mod[IDX_BITS-1:0];
        in_range  = (lat_addr < DEPTH_A);
        access_ok = in_range || ALIAS;
        do_access = (state == BUSY) && (wcount == 4'd0);
        cur_word  = mem[idx];
        merged    = cur_word;
        for (int k = 0; k < 4; k++) begin
            if (lat_be[k]) merged[8*k +: 8] = lat_data[8*k +: 8];
        end
    end

    // The FSM is forced to IDLE by reset, so a write in flight can never land.
    always_ff @(posedge clock) begin
        if (do_access && lat_write && access_ok) mem[idx] <= merged;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wcount    <= 4'd0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            data_out  <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_write <= write_en;
                        lat_addr  <= address;
                        lat_be    <= byte_en;
                        lat_data  <= data_in;
                        wcount    <= WAIT_LOAD;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (wcount != 4'd0) begin
                        wcount <= wcount - 4'd1;
                    end else begin
                        ready <= 1'b1;
                        state <= DONE;
                        if (access_ok) begin
                            fault    <= 1'b0;
                            data_out <= lat_write ? merged : cur_word;
                        end else begin
                            fault    <= 1'b1;
                            data_out <= '0;
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sigma_wait_memory.sv
// Scoreboard bench for sigma_wait_memory: four instances cover wait-state and
// alias variants; a negedge monitor checks every ready pulse against queued expectations.
module tb_sigma_wait_memory;
    typedef struct {
        int          inst;
        logic [0:31] data;
        logic        fault;
        int          cyc;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req      [4];
    logic        write_en [4];
    logic [16:0] address  [4];
    logic [0:3]  byte_en  [4];
    logic [0:31] data_in  [4];
    logic        ready    [4];
    logic        fault    [4];
    logic [0:31] data_out [4];

    exp_t sb [$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   tmo_count = 0;
    logic done = 1'b0;

    function automatic int ws_of(input int i);
        case (i)
            2:       return 0;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit alias_of(input int i);
        return (i == 1);
    endfunction

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sigma_wait_memory #(
            .ADDR_BITS  (17),
            .DEPTH      (128),
            .WAIT_STATES(ws_of(g)),
            .ALIAS      (alias_of(g)),
            .INIT_FILE  ("")
        ) u_dut (
            .clock   (clock),
            .reset   (reset),
            .req     (req[g]),
            .write_en(write_en[g]),
            .address (address[g]),
            .byte_en (byte_en[g]),
            .data_in (data_in[g]),
            .ready   (ready[g]),
            .data_out(data_out[g]),
            .fault   (fault[g])
        );
    end

    // Monitor: reset values while reset is low, scoreboard pops on every ready.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset === 1'b0) begin
                n_tests++;
                if (ready[i] !== 1'b0 || fault[i] !== 1'b0 || data_out[i] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_values inst %0d cyc %0d: ready=%b fault=%b data_out=%h, required 0 0 00000000",
                             i, cyc, ready[i], fault[i], data_out[i]);
                end
            end else if (ready[i] === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready inst %0d cyc %0d: data_out=%h fault=%b, no access outstanding",
                             i, cyc, data_out[i], fault[i]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.inst != i || mon_e.data !== data_out[i] || mon_e.fault !== fault[i] || mon_e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL %s: got inst %0d data=%h fault=%b cyc=%0d, required inst %0d data=%h fault=%b cyc=%0d",
                                 mon_e.name, i, data_out[i], fault[i], cyc, mon_e.inst, mon_e.data, mon_e.fault, mon_e.cyc);
                    end
                end
            end
        end
        if (done) begin
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            end
            n_tests++;
            if (tmo_count != 0) begin
                n_fail++;
                $display("FAIL ready_timeout: %0d waits expired, required 0", tmo_count);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic wait_ready(input int inst);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ready[inst] !== 1'b1 && n < 40);
        if (ready[inst] !== 1'b1) begin
            tmo_count++;
            $display("FAIL wait_ready inst %0d: ready=%b after %0d cycles, required 1", inst, ready[inst], n);
        end
    endtask

    task automatic drive(input int inst, input logic we, input logic [16:0] a,
                         input logic [0:3] be, input logic [0:31] d);
        write_en[inst] = we;
        address[inst]  = a;
        byte_en[inst]  = be;
        data_in[inst]  = d;
        req[inst]      = 1'b1;
    endtask

    // One access: accept edge is the next posedge, ready expected WS+1 edges later.
    task automatic access(input int inst, input logic we, input logic [16:0] a,
                          input logic [0:3] be, input logic [0:31] d,
                          input logic [0:31] exp_d, input logic exp_f, input string name);
        @(negedge clock);
        drive(inst, we, a, be, d);
        sb.push_back('{inst, exp_d, exp_f, cyc + 1 + ws_of(inst) + 1, name});
        wait_ready(inst);
        req[inst] = 1'b0;
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0; write_en[i] = 1'b0; address[i] = '0;
            byte_en[i] = '0; data_in[i] = '0;
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;

        // full write, read back, lane-selective writes, no-op write
        access(0, 1'b1, 17'd5, 4'b1111, 32'h12345678, 32'h12345678, 1'b0, "t1_wr5");
        access(0, 1'b0, 17'd5, 4'b0000, 32'h0,        32'h12345678, 1'b0, "t1_rd5");
        access(0, 1'b1, 17'd5, 4'b0100, 32'hAABBCCDD, 32'h12BB5678, 1'b0, "t2_wr5_lane1");
        access(0, 1'b0, 17'd5, 4'b1111, 32'h0,        32'h12BB5678, 1'b0, "t2_rd5");
        access(0, 1'b1, 17'd5, 4'b0000, 32'hFFFFFFFF, 32'h12BB5678, 1'b0, "t2_be0_noop");
        access(0, 1'b1, 17'd5, 4'b0001, 32'h000000EE, 32'h12BB56EE, 1'b0, "t2_wr5_lane3");
        access(0, 1'b0, 17'd5, 4'b0000, 32'h0,        32'h12BB56EE, 1'b0, "t2_rd5_lane3");

        // fault mode: out-of-range never writes, boundary 127/128
        access(0, 1'b1, 17'd72,  4'b1111, 32'h72727272, 32'h72727272, 1'b0, "t3_wr72");
        access(0, 1'b1, 17'd200, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b1, "t3_wr200_fault");
        access(0, 1'b0, 17'd200, 4'b1111, 32'h0,        32'h00000000, 1'b1, "t3_rd200_fault");
        access(0, 1'b0, 17'd72,  4'b1111, 32'h0,        32'h72727272, 1'b0, "t3_rd72_unchanged");
        access(0, 1'b1, 17'd127, 4'b1111, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, "t3_wr127_edge");
        access(0, 1'b0, 17'd128, 4'b1111, 32'h0,        32'h00000000, 1'b1, "t3_rd128_fault");

        // alias mode
        access(1, 1'b1, 17'd200, 4'b1111, 32'h0000CAFE, 32'h0000CAFE, 1'b0, "t3_alias_wr200");
        access(1, 1'b0, 17'd72,  4'b1111, 32'h0,        32'h0000CAFE, 1'b0, "t3_alias_rd72");
        access(1, 1'b0, 17'd200, 4'b0000, 32'h0,        32'h0000CAFE, 1'b0, "t3_alias_rd200");

        // async reset during BUSY drops the pending write
        access(0, 1'b1, 17'd9, 4'b1111, 32'h09090909, 32'h09090909, 1'b0, "t4_pre_wr9");
        @(negedge clock);
        drive(0, 1'b1, 17'd9, 4'b1111, 32'hFFFFFFFF);
        @(posedge clock);
        #2 reset = 1'b0;
        req[0] = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        access(0, 1'b0, 17'd9, 4'b1111, 32'h0, 32'h09090909, 1'b0, "t4_rd9_after_rst");

        // WAIT_STATES=0 with req held high across two reads
        access(2, 1'b1, 17'd1, 4'b1111, 32'h11111111, 32'h11111111, 1'b0, "t5_wr1");
        access(2, 1'b1, 17'd2, 4'b1111, 32'h22222222, 32'h22222222, 1'b0, "t5_wr2");
        @(negedge clock);
        drive(2, 1'b0, 17'd1, 4'b1111, 32'h0);
        t0 = cyc + 1;
        sb.push_back('{2, 32'h11111111, 1'b0, t0 + 1, "t5_held_rd1"});
        sb.push_back('{2, 32'h22222222, 1'b0, t0 + 4, "t5_held_rd2"});
        wait_ready(2);
        address[2] = 17'd2;
        wait_ready(2);
        req[2] = 1'b0;
        repeat (4) @(negedge clock);

        // WAIT_STATES=3 with req held through DONE
        access(3, 1'b1, 17'd3, 4'b1111, 32'h33333333, 32'h33333333, 1'b0, "t6_wr3");
        @(negedge clock);
        drive(3, 1'b0, 17'd3, 4'b1111, 32'h0);
        t0 = cyc + 1;
        sb.push_back('{3, 32'h33333333, 1'b0, t0 + 4,  "t6_held_rd3_a"});
        sb.push_back('{3, 32'h33333333, 1'b0, t0 + 10, "t6_held_rd3_b"});
        wait_ready(3);
        wait_ready(3);
        req[3] = 1'b0;

        repeat (5) @(negedge clock);
        #1 done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
